// File: rtl/if_id_if.sv
// IF/ID stage handshake bundle: fetch-side push, decode-side head view.
interface if_id_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        flush;
    logic        id_allow_in;
    logic        in_delayslot_i;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_shamt;
    logic [5:0]  id_func;
    logic        id_is_delayslot;
    logic        id_adel;

    modport master (
        output if_valid, if_pc, if_inst, flush,
        output id_allow_in, in_delayslot_i,
        input  if_ready, id_valid, id_pc, id_inst,
        input  id_op, id_rs, id_rt, id_shamt, id_func,
        input  id_is_delayslot, id_adel
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush,
        input  id_allow_in, in_delayslot_i,
        output if_ready, id_valid, id_pc, id_inst,
        output id_op, id_rs, id_rt, id_shamt, id_func,
        output id_is_delayslot, id_adel
    );
endinterface

// File: rtl/if_id_stage.sv
// IF->ID stage: small instruction FIFO with pre-split decode fields,
// delay-slot tagging and PC-misalignment (AdEL) flag.
module if_id_stage #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input logic   clk,
    input logic   rst,
    if_id_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              ds_pending;
    logic              push;
    logic              pop;
    entry_t            head;

    assign bus.if_ready = (count != FULL_CNT);
    assign bus.id_valid = (count != '0);

    assign push = bus.if_valid & bus.if_ready;
    assign pop  = bus.id_valid & bus.id_allow_in;

    assign head = mem[rd_ptr];

    assign bus.id_pc    = head.pc;
    assign bus.id_inst  = head.inst;
    assign bus.id_adel  = head.adel;
    assign bus.id_op    = head.inst[31:26];
    assign bus.id_rs    = head.inst[25:21];
    assign bus.id_rt    = head.inst[20:16];
    assign bus.id_shamt = head.inst[10:6];
    assign bus.id_func  = head.inst[5:0];

    assign bus.id_is_delayslot = ds_pending & bus.id_valid;

    // Flush only rewinds bookkeeping; stale entries stay but are unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{
                    pc:   bus.if_pc,
                    inst: bus.if_inst,
                    adel: (bus.if_pc[1:0] != 2'b00)
                };
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                ds_pending <= bus.in_delayslot_i;
            end
            unique case (1'b1)
                push && !pop: count <= count + CNT_ONE;
                pop && !push: count <= count - CNT_ONE;
                default:      ;
            endcase
        end
    end

endmodule
